// File: rtl/univ_shift_reg.sv
// Universal shift register: shifts, rotates, arithmetic shift right, parallel load
// and clear, with clock enable and a frame counter that pulses after WIDTH shifts.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             frame_done,
    output logic [CW-1:0]    frame_cnt
);

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SHR  = 3'b001,
        SHL  = 3'b010,
        ROR  = 3'b011,
        ROL  = 3'b100,
        LOAD = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_e;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mode_e            op;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             is_shift;
    logic             cnt_clr;

    assign op = mode_e'(mode);

    always_comb begin
        q_nxt    = q;
        is_shift = 1'b0;
        cnt_clr  = 1'b0;
        case (op)
            HOLD: q_nxt = q;
            SHR: begin
                q_nxt    = {sin_msb, q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            SHL: begin
                q_nxt    = {q[WIDTH-2:0], sin_lsb};
                is_shift = 1'b1;
            end
            ROR: begin
                q_nxt    = {q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            ROL: begin
                q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                is_shift = 1'b1;
            end
            LOAD: begin
                q_nxt   = par_in;
                cnt_clr = 1'b1;
            end
            ASR: begin
                q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            CLR: begin
                q_nxt   = '0;
                cnt_clr = 1'b1;
            end
            default: q_nxt = q;
        endcase
    end

    // frame_done defaults low every edge so it can never stretch past one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                q <= q_nxt;
                if (is_shift) begin
                    if (frame_cnt == LAST) begin
                        frame_cnt  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end else if (cnt_clr) begin
                    frame_cnt <= '0;
                end
            end
        end
    end

    assign par_out  = q;
    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=4: directed steps push hand-computed
// expectations, a monitor pops and compares one entry after each rising edge.
module tb_univ_shift_reg;

    localparam int W  = 4;
    localparam int CW = 3;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          sin_msb;
    logic          sin_lsb;
    logic [W-1:0]  par_in;
    logic [W-1:0]  par_out;
    logic          sout_lsb;
    logic          sout_msb;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;

    typedef struct {
        string         name;
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .par_in     (par_in),
        .par_out    (par_out),
        .sout_lsb   (sout_lsb),
        .sout_msb   (sout_msb),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        logic [W-1:0] eq;
        eq = e.q;
        n_tests++;
        if (par_out !== e.q || frame_cnt !== e.cnt || frame_done !== e.done ||
            sout_lsb !== eq[0] || sout_msb !== eq[W-1]) begin
            n_fail++;
            $display("FAIL %s: got q=%b cnt=%0d done=%b slsb=%b smsb=%b, want q=%b cnt=%0d done=%b slsb=%b smsb=%b",
                     e.name, par_out, frame_cnt, frame_done, sout_lsb, sout_msb,
                     e.q, e.cnt, e.done, eq[0], eq[W-1]);
        end
    endtask

    // drive one operation ahead of the next rising edge and queue its expected result
    task automatic step(input string name, input logic e_n, input logic [2:0] m,
                        input logic smsb, input logic slsb, input logic [W-1:0] pin,
                        input logic [W-1:0] xq, input logic [CW-1:0] xc, input logic xd);
        exp_t e;
        @(negedge clk);
        en      = e_n;
        mode    = m;
        sin_msb = smsb;
        sin_lsb = slsb;
        par_in  = pin;
        e.name = name;
        e.q    = xq;
        e.cnt  = xc;
        e.done = xd;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) check(sb.pop_front());
    end

    initial begin
        exp_t z;
        z.name = "reset";
        z.q    = '0;
        z.cnt  = '0;
        z.done = 1'b0;
        rst = 1'b1; en = 1'b0; mode = M_HOLD; sin_msb = 1'b0; sin_lsb = 1'b0; par_in = '0;
        #1 check(z);
        @(negedge clk) rst = 1'b0;

        // reach q=1011, cnt=2, then assert reset between edges
        step("pre_load",  1, M_LOAD, 0, 0, 4'b1110, 4'b1110, 0, 0);
        step("pre_rol1",  1, M_ROL,  0, 0, 4'b0000, 4'b1101, 1, 0);
        step("pre_rol2",  1, M_ROL,  0, 0, 4'b0000, 4'b1011, 2, 0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        z.name = "async_reset";
        #1 check(z);
        #1 rst = 1'b0;

        // SHL deserialise 1,1,0,1
        step("shl_clr",   1, M_CLR,  0, 0, 4'b1111, 4'b0000, 0, 0);
        step("shl_1",     1, M_SHL,  0, 1, 4'b0000, 4'b0001, 1, 0);
        step("shl_2",     1, M_SHL,  0, 1, 4'b0000, 4'b0011, 2, 0);
        step("shl_3",     1, M_SHL,  0, 0, 4'b0000, 4'b0110, 3, 0);
        step("shl_4",     1, M_SHL,  0, 1, 4'b0000, 4'b1101, 0, 1);
        step("shl_hold",  1, M_HOLD, 0, 0, 4'b0000, 4'b1101, 0, 0);

        // SHR serialise 1101: sout_lsb 1,0,1,1
        step("shr_load",  1, M_LOAD, 1, 1, 4'b1101, 4'b1101, 0, 0);
        step("shr_1",     1, M_SHR,  0, 1, 4'b0000, 4'b0110, 1, 0);
        step("shr_2",     1, M_SHR,  0, 1, 4'b0000, 4'b0011, 2, 0);
        step("shr_3",     1, M_SHR,  0, 1, 4'b0000, 4'b0001, 3, 0);
        step("shr_4",     1, M_SHR,  0, 1, 4'b0000, 4'b0000, 0, 1);

        // rotate / arithmetic shift
        step("rot_load",  1, M_LOAD, 0, 0, 4'b1001, 4'b1001, 0, 0);
        step("rot_rol",   1, M_ROL,  1, 1, 4'b0000, 4'b0011, 1, 0);
        step("rot_ror",   1, M_ROR,  0, 0, 4'b0000, 4'b1001, 2, 0);
        step("rot_asr1",  1, M_ASR,  0, 0, 4'b0000, 4'b1100, 3, 0);
        step("rot_asr2",  1, M_ASR,  0, 0, 4'b0000, 4'b1110, 0, 1);

        // enable and hold gaps inside a frame
        step("gap_clr",   1, M_CLR,  0, 0, 4'b0000, 4'b0000, 0, 0);
        step("gap_shl1",  1, M_SHL,  0, 1, 4'b0000, 4'b0001, 1, 0);
        step("gap_en0a",  0, M_SHL,  1, 1, 4'b0000, 4'b0001, 1, 0);
        step("gap_hold1", 1, M_HOLD, 1, 1, 4'b0000, 4'b0001, 1, 0);
        step("gap_shl2",  1, M_SHL,  0, 0, 4'b0000, 4'b0010, 2, 0);
        step("gap_en0b",  0, M_CLR,  0, 0, 4'b0000, 4'b0010, 2, 0);
        step("gap_shl3",  1, M_SHL,  0, 1, 4'b0000, 4'b0101, 3, 0);
        step("gap_hold2", 1, M_HOLD, 0, 0, 4'b0000, 4'b0101, 3, 0);
        step("gap_en0c",  0, M_LOAD, 0, 0, 4'b1111, 4'b0101, 3, 0);
        step("gap_shl4",  1, M_SHL,  0, 1, 4'b0000, 4'b1011, 0, 1);
        step("gap_after", 1, M_HOLD, 0, 0, 4'b0000, 4'b1011, 0, 0);

        // abort a partial frame with LOAD, then a full mixed-direction frame
        step("ab_shl1",   1, M_SHL,  0, 0, 4'b0000, 4'b0110, 1, 0);
        step("ab_shl2",   1, M_SHL,  0, 0, 4'b0000, 4'b1100, 2, 0);
        step("ab_load",   1, M_LOAD, 0, 0, 4'b0110, 4'b0110, 0, 0);
        step("ab_shr",    1, M_SHR,  1, 0, 4'b0000, 4'b1011, 1, 0);
        step("ab_shl",    1, M_SHL,  1, 0, 4'b0000, 4'b0110, 2, 0);
        step("ab_ror",    1, M_ROR,  1, 1, 4'b0000, 4'b0011, 3, 0);
        step("ab_rol",    1, M_ROL,  0, 0, 4'b0000, 4'b0110, 0, 1);
        step("ab_en0",    0, M_SHL,  1, 1, 4'b0000, 4'b0110, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d entries pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
